solver_out_decimator: RTL and testbench
=======================================

// Module: solver_out_decimator
// PURPOSE
//  Downstream stage of the integer RK4 motor solver. Consumes 64-bit i/w state on
//  each solver update strobe, box-car averages 2^DEC_LOG2 updates, rescales and
//  saturates each to signed 32 bits and buffers {w,i} pairs in a FIFO. The FIFO is
//  drained over a valid/ready handshake toward the AXI register/DMA side.
// PARAMETERS
//  DEC_LOG2   2   log2 of updates averaged per output sample (0..8)
//  OUT_SHIFT  16  arithmetic right shift applied to the average before saturation (0..32)
//  FIFO_AW    4   FIFO address width; depth = 2^FIFO_AW entries
// PORTS
//  clk        in   1           solver clock
//  rst_n      in   1           reset: asynchronous, active-low
//  en         in   1           0: accumulator and sample counter held cleared, no pushes
//  upd        in   1           one-cycle strobe: i_in/w_in hold a new solver value (the solver's tmr phase)
//  i_in       in   64          solver current, two's complement
//  w_in       in   64          solver speed, two's complement
//  m_valid    out  1           FIFO non-empty
//  m_ready    in   1           consumer accepts head when m_valid & m_ready
//  m_data     out  64          {w_sat[31:0], i_sat[31:0]} at FIFO head
//  fill       out  FIFO_AW+1   current FIFO occupancy
//  ovf_cnt    out  16          dropped-sample count, saturates at 0xFFFF
//  ovf        out  1           sticky: set on any drop
//  clr_ovf    in   1           synchronous clear of ovf_cnt and ovf
// BEHAVIOUR
//  Reset: acc_i/acc_w=0, sample cnt=0, stage regs invalid, FIFO empty; m_valid=0,
//   m_data=0, fill=0, ovf_cnt=0, ovf=0.
//  Accumulate: on upd&en, acc += sign-extended input (width 64+DEC_LOG2, no overflow);
//   cnt increments. On the upd that makes cnt == 2^DEC_LOG2-1 -> 0 (Nth sample):
//   the final sum (including this sample) is latched to the stage-1 registers, acc
//   restarts from 0 on the next upd, stage-1 valid is set for 1 cycle.
//  Scale (stage 2, cycle after latch): v = sum >>> (DEC_LOG2+OUT_SHIFT), arithmetic.
//   If v > 0x7FFFFFFF -> 0x7FFFFFFF; if v < -2^31 -> 0x80000000; else v[31:0].
//   Performed independently for i and w.
//  Push: the cycle after stage 2 the pair is written to the FIFO. Latency from the Nth
//   upd edge to m_valid high: 3 clk edges (latch, scale, write); m_valid is
//   combinational from non-empty. m_data shows the head (first-word fall-through).
//  Handshake: pop when m_valid & m_ready. m_data stable while m_valid & !m_ready.
//  Full: a push while full with no pop in the same cycle is dropped: ovf_cnt += 1
//   (saturating), ovf=1. A push while full with a simultaneous pop is accepted;
//   fill unchanged. A push and pop on a non-empty, non-full FIFO leave fill unchanged.
//  Empty: m_ready ignored when m_valid=0; pointers do not move.
//  clr_ovf the same cycle as a drop: clear wins (count=0, ovf=0).
//  en deasserted: acc/cnt cleared immediately, samples already in stages 1/2 complete
//   and are pushed; FIFO contents untouched. upd ignored while en=0.
//  upd every cycle is legal (no 2-cycle spacing is required).
//  Pointers wrap modulo 2^FIFO_AW; fill is computed from the extra MSB.
// TESTING
//  1 DEC_LOG2=2,OUT_SHIFT=16: 4 upd with i=0x10000,w=0x30000 -> one entry 0x00000003_00000001,
//    m_valid high 3 edges after the 4th upd.
//  2 i=0x0000800000000000 x4 -> i_sat=0x7FFFFFFF; i=-(2^50) x4 -> i_sat=0x80000000.
//  3 Signed average: i = 0x10000,0x10000,-0x10000,-0x30000 -> sum -0x20000, i_sat=0xFFFFFFFF.
//  4 m_ready=0, push 18 samples (depth 16) -> fill=16, ovf_cnt=2, ovf=1; drain -> 16 entries
//    in order; clr_ovf -> 0.
//  5 Full FIFO, push cycle coincident with m_ready=1 -> no drop, fill stays 16, order intact.
//  6 rst_n low mid-accumulation (2 of 4 samples) and with FIFO non-empty -> all outputs
//    0 asynchronously; after release 4 new upds produce a sample excluding pre-reset data.

Source files
------------

// File: rtl/solver_out_decimator_if.sv
// Output stream of the solver decimator: {w,i} sample pairs over valid/ready.
interface solver_out_decimator_if;
   logic        m_valid;
   logic        m_ready;
   logic [63:0] m_data;

   modport master (output m_valid, output m_data, input m_ready);
   modport slave  (input m_valid, input m_data, output m_ready);
endinterface

// File: rtl/solver_out_decimator.sv
// Box-car decimator for RK4 solver i/w state: average, rescale, saturate to
// signed 32 bits and buffer {w,i} pairs in a first-word fall-through FIFO.
module solver_out_decimator #(
   parameter int DEC_LOG2  = 2,
   parameter int OUT_SHIFT = 16,
   parameter int FIFO_AW   = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  en,
   input  logic                  upd,
   input  logic [63:0]           i_in,
   input  logic [63:0]           w_in,
   solver_out_decimator_if.master m_if,
   output logic [FIFO_AW:0]      fill,
   output logic [15:0]           ovf_cnt,
   output logic                  ovf,
   input  logic                  clr_ovf
);

   localparam int AW    = 64 + DEC_LOG2;
   localparam int CNT_W = DEC_LOG2 + 1;
   localparam int SH    = DEC_LOG2 + OUT_SHIFT;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << DEC_LOG2) - 1);

   logic signed [AW-1:0] acc_i, acc_w;
   logic signed [AW-1:0] sum_i, sum_w;
   logic [CNT_W-1:0]     cnt;
   logic signed [AW-1:0] s1_i, s1_w;
   logic                 s1_v;
   logic [63:0]          s2_data;
   logic                 s2_v;

   logic [63:0]          mem [2**FIFO_AW];
   logic [FIFO_AW:0]     wr_ptr, rd_ptr;
   logic                 empty, full, pop, push, drop;

   // Anything beyond the signed 32-bit range clamps; the upper bits must all
   // match the sign bit for the value to be representable.
   function automatic logic [31:0] sat32(input logic signed [AW-1:0] v);
      logic [AW-1:0] u;
      u = v;
      if (!u[AW-1] && (|u[AW-2:31]))
         return 32'h7FFF_FFFF;
      else if (u[AW-1] && !(&u[AW-2:31]))
         return 32'h8000_0000;
      else
         return u[31:0];
   endfunction

   assign sum_i = acc_i + AW'($signed(i_in));
   assign sum_w = acc_w + AW'($signed(w_in));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_i <= '0;
         acc_w <= '0;
         cnt   <= '0;
         s1_i  <= '0;
         s1_w  <= '0;
         s1_v  <= 1'b0;
      end else begin
         s1_v <= 1'b0;
         if (!en) begin
            acc_i <= '0;
            acc_w <= '0;
            cnt   <= '0;
         end else if (upd) begin
            if (cnt == CNT_LAST) begin
               s1_i  <= sum_i;
               s1_w  <= sum_w;
               s1_v  <= 1'b1;
               acc_i <= '0;
               acc_w <= '0;
               cnt   <= '0;
            end else begin
               acc_i <= sum_i;
               acc_w <= sum_w;
               cnt   <= cnt + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_data <= '0;
         s2_v    <= 1'b0;
      end else begin
         s2_v <= s1_v;
         if (s1_v)
            s2_data <= {sat32(s1_w >>> SH), sat32(s1_i >>> SH)};
      end
   end

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                  (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign pop   = !empty && m_if.m_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign push  = s2_v && (!full || pop);
   assign drop  = s2_v && full && !pop;

   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr[FIFO_AW-1:0]] <= s2_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         ovf_cnt <= '0;
         ovf     <= 1'b0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (clr_ovf) begin
            ovf_cnt <= '0;
            ovf     <= 1'b0;
         end else if (drop) begin
            ovf <= 1'b1;
            if (ovf_cnt != 16'hFFFF)
               ovf_cnt <= ovf_cnt + 16'd1;
         end
      end
   end

   assign fill         = wr_ptr - rd_ptr;
   assign m_if.m_valid = !empty;
   assign m_if.m_data  = empty ? 64'd0 : mem[rd_ptr[FIFO_AW-1:0]];

endmodule

// File: tb/tb_solver_out_decimator.sv
// Scoreboard bench for solver_out_decimator at default parameters (4-sample average, >>>18).
module tb_solver_out_decimator;

   typedef logic signed [63:0] quad_t [4];

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        upd = 1'b0;
   logic [63:0] i_in = '0;
   logic [63:0] w_in = '0;
   logic [4:0]  fill;
   logic [15:0] ovf_cnt;
   logic        ovf;
   logic        clr_ovf = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   logic [63:0] sb [$];

   solver_out_decimator_if bus ();

   solver_out_decimator dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (en),
      .upd     (upd),
      .i_in    (i_in),
      .w_in    (w_in),
      .m_if    (bus.master),
      .fill    (fill),
      .ovf_cnt (ovf_cnt),
      .ovf     (ovf),
      .clr_ovf (clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] model_sat(input quad_t v);
      logic signed [65:0] sum;
      logic signed [65:0] q;
      sum = '0;
      for (int k = 0; k < 4; k++)
         sum = sum + {{2{v[k][63]}}, v[k]};
      q = sum >>> 18;
      if (q > 66'sh7FFF_FFFF)
         return 32'h7FFF_FFFF;
      else if (q < -66'sh8000_0000)
         return 32'h8000_0000;
      else
         return q[31:0];
   endfunction

   // Four back-to-back updates; returns at the negedge just after the latching edge.
   task automatic grp(input quad_t iv, input quad_t wv);
      sb.push_back({model_sat(wv), model_sat(iv)});
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         upd  = 1'b1;
         i_in = iv[k];
         w_in = wv[k];
      end
      @(negedge clk);
      upd = 1'b0;
   endtask

   task automatic drain(input bit rnd);
      int budget;
      bit r;
      budget = 0;
      while (sb.size() != 0 && budget < 500) begin
         @(negedge clk);
         r = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         bus.m_ready = r;
         if (bus.m_valid && r)
            chk("data", bus.m_data, sb.pop_front());
         budget++;
      end
      if (sb.size() != 0) begin
         chk("drain_timeout", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      @(negedge clk);
      bus.m_ready = 1'b0;
      chk("fill_after_drain", 64'(fill), 64'd0);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      quad_t a, b;
      bus.m_ready = 1'b0;
      #12;
      chk("rst_valid", 64'(bus.m_valid), 64'd0);
      chk("rst_data", bus.m_data, 64'd0);
      chk("rst_fill", 64'(fill), 64'd0);
      chk("rst_ovf", {47'd0, ovf, ovf_cnt}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      en = 1'b1;

      // basic average plus 3-edge latency
      a = '{64'h10000, 64'h10000, 64'h10000, 64'h10000};
      b = '{64'h30000, 64'h30000, 64'h30000, 64'h30000};
      grp(a, b);
      chk("lat_e1", 64'(bus.m_valid), 64'd0);
      @(negedge clk);
      chk("lat_e2", 64'(bus.m_valid), 64'd0);
      @(negedge clk);
      chk("lat_e3", 64'(bus.m_valid), 64'd1);
      chk("basic_value", bus.m_data, 64'h00000003_00000001);
      drain(1'b0);

      // saturation both ways, signed average
      a = '{64'h0000800000000000, 64'h0000800000000000, 64'h0000800000000000, 64'h0000800000000000};
      b = '{-64'sd1125899906842624, -64'sd1125899906842624, -64'sd1125899906842624, -64'sd1125899906842624};
      grp(a, b);
      a = '{64'sh10000, 64'sh10000, -64'sh10000, -64'sh30000};
      b = '{64'sh7FFF0000, 64'sh0, -64'sh5, 64'sh12345};
      grp(a, b);
      idle(4);
      drain(1'b0);

      // random values, back-pressured drain
      for (int g = 0; g < 6; g++) begin
         for (int k = 0; k < 4; k++) begin
            a[k] = {$urandom(), $urandom()} >>> $urandom_range(0, 40);
            b[k] = {$urandom(), $urandom()} >>> $urandom_range(0, 40);
         end
         grp(a, b);
      end
      idle(4);
      drain(1'b1);

      // en low in the middle of a group discards the partial sum
      a = '{64'h7000000000, 64'h7000000000, 64'h7000000000, 64'h7000000000};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         upd = 1'b1; i_in = a[k]; w_in = a[k];
      end
      @(negedge clk);
      upd = 1'b0; en = 1'b0;
      @(negedge clk);
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0; en = 1'b1;
      a = '{64'h40000, 64'h40000, 64'h0, 64'h0};
      b = '{64'h0, 64'h0, 64'h0, -64'sh40000};
      grp(a, b);
      idle(4);
      drain(1'b0);

      // overflow: 18 samples into depth 16
      for (int g = 0; g < 18; g++) begin
         for (int k = 0; k < 4; k++) begin
            a[k] = 64'(g) * 64'h10000;
            b[k] = -(64'(g) * 64'h10000);
         end
         grp(a, b);
      end
      idle(4);
      void'(sb.pop_back());
      void'(sb.pop_back());
      chk("full_fill", 64'(fill), 64'd16);
      chk("ovf_cnt", 64'(ovf_cnt), 64'd2);
      chk("ovf_flag", 64'(ovf), 64'd1);
      drain(1'b0);
      chk("ovf_kept", 64'(ovf_cnt), 64'd2);
      @(negedge clk);
      clr_ovf = 1'b1;
      @(negedge clk);
      clr_ovf = 1'b0;
      chk("ovf_clr", {47'd0, ovf, ovf_cnt}, 64'd0);

      // push into a full FIFO coincident with a pop
      for (int g = 0; g < 17; g++) begin
         for (int k = 0; k < 4; k++) begin
            a[k] = 64'(g + 3) * 64'h20000;
            b[k] = 64'(g) * 64'h40000;
         end
         grp(a, b);
         if (g == 15) begin
            idle(3);
            chk("pre_full", 64'(fill), 64'd16);
         end
      end
      @(negedge clk);
      bus.m_ready = 1'b1;
      chk("coinc_head", bus.m_data, sb.pop_front());
      @(negedge clk);
      bus.m_ready = 1'b0;
      chk("coinc_fill", 64'(fill), 64'd16);
      chk("coinc_ovf", {47'd0, ovf, ovf_cnt}, 64'd0);
      drain(1'b0);

      // async reset mid-accumulation with data buffered
      a = '{64'h10000, 64'h20000, 64'h30000, 64'h40000};
      grp(a, a);
      idle(4);
      a = '{64'h7FFF000000, 64'h7FFF000000, 64'h7FFF000000, 64'h7FFF000000};
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         upd = 1'b1; i_in = a[k]; w_in = a[k];
      end
      @(negedge clk);
      upd = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(bus.m_valid), 64'd0);
      chk("arst_data", bus.m_data, 64'd0);
      chk("arst_fill", 64'(fill), 64'd0);
      sb.delete();
      @(negedge clk);
      rst_n = 1'b1;
      a = '{64'h40000, 64'h40000, 64'h40000, 64'h40000};
      b = '{-64'sh40000, -64'sh40000, -64'sh40000, -64'sh40000};
      grp(a, b);
      idle(3);
      chk("post_rst_fill", 64'(fill), 64'd1);
      drain(1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
